// File: rtl/neuron_accumulator_pkg.sv
// Shared constants and FSM state type for the neuron accumulator datapath.
package neuron_accumulator_pkg;

  // Sign-magnitude operand width (1 sign + 7 magnitude bits).
  localparam int SM_W   = 8;
  // Multiplier product width (1 sign + 14 magnitude bits).
  localparam int PROD_W = 15;
  // Fraction bits per operand.
  localparam int FRAC_W = 7;
  // Largest magnitude representable in an SM_W sign-magnitude word.
  localparam int SM_MAX = (1 << (SM_W - 1)) - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    SCALE = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/neuron_accumulator_if.sv
// Handshake bundle between the accumulator and its driver.
//
// Handshakes: a product moves when prod_valid && prod_ready at a rising edge;
// a result moves when out_valid && out_ready at a rising edge. The source holds
// its payload stable while valid is high and the beat has not yet transferred.
interface neuron_accumulator_if;
  import neuron_accumulator_pkg::*;

  logic              start;
  logic [SM_W-1:0]   bias;
  logic              prod_valid;
  logic [PROD_W-1:0] prod;
  logic              prod_ready;
  logic              out_valid;
  logic              out_ready;
  logic [SM_W-1:0]   out;
  logic              busy;

  // Driver side: issues start/bias and products, consumes results.
  modport master (
    output start, bias, prod_valid, prod, out_ready,
    input  prod_ready, out_valid, out, busy
  );

  // Accumulator side.
  modport slave (
    input  start, bias, prod_valid, prod, out_ready,
    output prod_ready, out_valid, out, busy
  );

endinterface

// File: rtl/neuron_accumulator_sm2tc.sv
// Sign-magnitude to two's-complement conversion, zero-extended magnitude then
// negated when the sign is set. Negative zero maps to zero.
module neuron_accumulator_sm2tc #(
  parameter int MAG_W = 14,
  parameter int OUT_W = 20
) (
  input  logic             sign_i,
  input  logic [MAG_W-1:0] mag_i,
  output logic [OUT_W-1:0] val_o
);

  logic [OUT_W-1:0] mag_ext;

  // Widen the magnitude, then negate it for negative inputs.
  always_comb begin
    mag_ext = OUT_W'(mag_i);
    val_o   = sign_i ? (OUT_W'(0) - mag_ext) : mag_ext;
  end

endmodule

// File: rtl/neuron_accumulator.sv
// Neuron accumulator: sums N_INPUTS sign-magnitude products plus a scaled bias
// in two's complement, then rescales, applies ReLU and saturates to an 8-bit
// sign-magnitude output.
module neuron_accumulator
  import neuron_accumulator_pkg::*;
#(
  parameter int N_INPUTS  = 8,
  parameter int ACC_W     = 20,
  parameter int OUT_SHIFT = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  neuron_accumulator_if.slave  bus,
  output state_t               state_o
);

  localparam int CNT_W  = (N_INPUTS < 2) ? 1 : $clog2(N_INPUTS + 1);
  localparam int BIAS_W = SM_W - 1 + OUT_SHIFT;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_INPUTS - 1);

  state_t            state_q;
  logic [ACC_W-1:0]  acc_q;
  logic [ACC_W-1:0]  acc_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              prod_ready_q;
  logic              out_valid_q;
  logic [SM_W-1:0]   out_q;
  logic              busy_q;

  logic [BIAS_W-1:0] bias_mag;
  logic [ACC_W-1:0]  bias_tc;
  logic [ACC_W-1:0]  prod_tc;
  logic              prod_xfer;

  logic [ACC_W-1:0]  acc_abs;
  logic [ACC_W-1:0]  acc_shr;
  logic [SM_W-2:0]   sat_mag;
  logic [SM_W-1:0]   scaled_out;

  // Bias magnitude is aligned to the product's 14 fraction bits.
  assign bias_mag = BIAS_W'(bus.bias[SM_W-2:0]) << OUT_SHIFT;

  neuron_accumulator_sm2tc #(
    .MAG_W (BIAS_W),
    .OUT_W (ACC_W)
  ) u_bias_conv (
    .sign_i (bus.bias[SM_W-1]),
    .mag_i  (bias_mag),
    .val_o  (bias_tc)
  );

  neuron_accumulator_sm2tc #(
    .MAG_W (PROD_W - 1),
    .OUT_W (ACC_W)
  ) u_prod_conv (
    .sign_i (bus.prod[PROD_W-1]),
    .mag_i  (bus.prod[PROD_W-2:0]),
    .val_o  (prod_tc)
  );

  assign prod_xfer = bus.prod_valid && prod_ready_q;
  assign acc_d     = acc_q + prod_tc;
  assign cnt_d     = cnt_q + CNT_W'(1);

  // Rescale the accumulated sum: truncate magnitude toward zero, clamp to the
  // output range, and force negative sums to zero.
  always_comb begin
    acc_abs = acc_q[ACC_W-1] ? (ACC_W'(0) - acc_q) : acc_q;
    acc_shr = acc_abs >> OUT_SHIFT;
    if (acc_shr > ACC_W'(SM_MAX)) begin
      sat_mag = '1;
    end else begin
      sat_mag = acc_shr[SM_W-2:0];
    end
    scaled_out = acc_q[ACC_W-1] ? '0 : {1'b0, sat_mag};
  end

  // Control FSM with accumulator, counter and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      cnt_q        <= '0;
      prod_ready_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_q        <= '0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            acc_q        <= bias_tc;
            cnt_q        <= '0;
            prod_ready_q <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= ACC;
          end
        end
        ACC: begin
          if (prod_xfer) begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            if (cnt_q == CNT_LAST) begin
              prod_ready_q <= 1'b0;
              state_q      <= SCALE;
            end
          end
        end
        SCALE: begin
          out_q       <= scaled_out;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.prod_ready = prod_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out        = out_q;
  assign bus.busy       = busy_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_neuron_accumulator.sv
// Directed bench for neuron_accumulator with a queue-based scoreboard.
module tb_neuron_accumulator;
  import neuron_accumulator_pkg::*;

  logic   clk = 1'b0;
  logic   rst;
  state_t state;

  neuron_accumulator_if bus();

  neuron_accumulator #(
    .N_INPUTS  (8),
    .ACC_W     (20),
    .OUT_SHIFT (7)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (state)
  );

  // Clock
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [7:0]  exp_q[$];
  logic [14:0] pv[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever a result handshake is about to occur.
  initial begin : monitor
    logic [7:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output: got %0h expected none", bus.out);
        end else begin
          e = exp_q.pop_front();
          check("result", {24'b0, bus.out}, {24'b0, e});
        end
      end
    end
  end

  // Drivers
  task automatic fill(input logic [14:0] a, input logic [14:0] b);
    for (int i = 0; i < 8; i++) pv[i] = (i % 2 == 0) ? a : b;
  endtask

  task automatic do_start(input logic [7:0] b, input logic [7:0] expv, input bit push);
    @(negedge clk);
    bus.start = 1'b1;
    bus.bias  = b;
    if (push) exp_q.push_back(expv);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic send_prod(input logic [14:0] p, input int gap, input bit with_start);
    int budget;
    budget = 0;
    bus.prod_valid = 1'b1;
    bus.prod       = p;
    if (with_start) begin
      bus.start = 1'b1;
      bus.bias  = 8'h7F;
    end
    @(posedge clk);
    while (bus.prod_ready !== 1'b1 && budget < 50) begin
      @(posedge clk);
      budget++;
    end
    if (budget >= 50) begin
      checks++;
      failures++;
      $display("FAIL prod_ready_timeout: got 0 expected 1");
    end
    @(negedge clk);
    bus.prod_valid = 1'b0;
    bus.start      = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_in_time", {31'b0, (n < 100)}, 32'd1);
  endtask

  task automatic run(input logic [7:0] b, input logic [7:0] expv, input int gap, input int start_at);
    do_start(b, expv, 1'b1);
    for (int i = 0; i < 8; i++) send_prod(pv[i], gap, (i == start_at));
    wait_drain();
  endtask

  initial begin
    int n;
    bus.start      = 1'b0;
    bus.bias       = 8'h00;
    bus.prod_valid = 1'b0;
    bus.prod       = 15'h0;
    bus.out_ready  = 1'b1;
    rst            = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("reset_busy",       {31'b0, bus.busy},       32'd0);
    check("reset_out_valid",  {31'b0, bus.out_valid},  32'd0);
    check("reset_prod_ready", {31'b0, bus.prod_ready}, 32'd0);
    check("reset_out",        {24'b0, bus.out},        32'd0);
    check("reset_state",      32'(state),              32'(IDLE));
    @(negedge clk);
    rst = 1'b0;

    // prod_valid in IDLE must be ignored
    @(negedge clk);
    bus.prod_valid = 1'b1;
    bus.prod       = 15'h3F01;
    repeat (3) @(negedge clk);
    bus.prod_valid = 1'b0;
    #1;
    check("idle_prod_ignored_state", 32'(state), 32'(IDLE));
    check("idle_prod_ignored_busy",  {31'b0, bus.busy}, 32'd0);

    // 8 x 256 + 0 = 2048 -> 16
    fill(15'h0100, 15'h0100); run(8'h00, 8'h10, 0, -1);
    // -128 + 4*8 - 4*8 = -128 -> ReLU
    fill(15'h0008, 15'h4008); run(8'h81, 8'h00, 0, -1);
    // 16256 + 8*16129 -> saturate
    fill(15'h3F01, 15'h3F01); run(8'h7F, 8'h7F, 0, -1);
    // negative zero products and bias
    fill(15'h4000, 15'h0000); run(8'h80, 8'h00, 0, -1);
    fill(15'h4000, 15'h4000); run(8'h05, 8'h05, 0, -1);
    fill(15'h0080, 15'h0080); run(8'h80, 8'h08, 0, -1);
    // gapped products give the same result as back-to-back
    fill(15'h0100, 15'h0100); run(8'h00, 8'h10, 1, -1);
    // exactly 127<<7
    fill(15'h0000, 15'h0000); run(8'h7F, 8'h7F, 0, -1);
    fill(15'h0000, 15'h0000); pv[5] = 15'h0080; run(8'h7E, 8'h7F, 0, -1);
    // 16255 truncates to 126
    fill(15'h0000, 15'h0000); pv[2] = 15'h007F; run(8'h7E, 8'h7E, 0, -1);
    // 128 over the limit saturates
    fill(15'h0000, 15'h0000); pv[7] = 15'h0080; run(8'h7F, 8'h7F, 0, -1);
    // 255 >> 7 = 1
    fill(15'h0000, 15'h0000); pv[0] = 15'h00FF; run(8'h00, 8'h01, 0, -1);
    // -129 -> ReLU even though |acc|>>7 is nonzero
    fill(15'h0000, 15'h0000); pv[0] = 15'h4081; run(8'h00, 8'h00, 0, -1);
    // 128 - 1 = 127 -> 0
    fill(15'h0000, 15'h0000); pv[3] = 15'h4001; run(8'h01, 8'h00, 0, -1);
    // -2048 + 8*512 = 2048 -> 16
    fill(15'h0200, 15'h0200); run(8'h90, 8'h10, 0, -1);
    // start asserted with a product in ACC: product only
    fill(15'h0100, 15'h0100); run(8'h00, 8'h10, 0, 3);

    // Back-pressure: 384 + 8*64 = 896 -> 7
    bus.out_ready = 1'b0;
    fill(15'h0040, 15'h0040);
    do_start(8'h03, 8'h07, 1'b1);
    for (int i = 0; i < 8; i++) send_prod(pv[i], 0, 1'b0);
    n = 0;
    #1;
    while (bus.out_valid !== 1'b1 && n < 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("out_valid_rises", {31'b0, bus.out_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.start = (i == 2);
      bus.bias  = 8'h7F;
      #1;
      check("hold_out_valid", {31'b0, bus.out_valid}, 32'd1);
      check("hold_out",       {24'b0, bus.out},       32'h07);
      check("hold_busy",      {31'b0, bus.busy},      32'd1);
    end
    check("hold_state", 32'(state), 32'(DONE));
    // handshake with a simultaneous start: start ignored
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    #1;
    check("after_hs_busy",  {31'b0, bus.busy}, 32'd0);
    check("after_hs_state", 32'(state),        32'(IDLE));
    @(negedge clk);
    #1;
    check("start_in_done_ignored", {31'b0, bus.busy}, 32'd0);
    check("queue_empty_after_hs",  32'(exp_q.size()), 32'd0);

    // Reset mid-accumulation
    fill(15'h3F01, 15'h3F01);
    do_start(8'h7F, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) send_prod(pv[i], 0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("midrst_busy",       {31'b0, bus.busy},       32'd0);
    check("midrst_out_valid",  {31'b0, bus.out_valid},  32'd0);
    check("midrst_prod_ready", {31'b0, bus.prod_ready}, 32'd0);
    check("midrst_out",        {24'b0, bus.out},        32'd0);
    check("midrst_state",      32'(state),              32'(IDLE));
    rst = 1'b0;
    // fresh run: 256 + 8*128 = 1280 -> 10
    fill(15'h0080, 15'h0080); run(8'h02, 8'h0A, 0, -1);

    repeat (4) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
